// File: rtl/insn_buffer.sv
// Halfword-granular instruction queue between fetch and decode: splits 32-bit fetch
// words into tagged 16-bit entries and presents the two oldest entries to decode.
module insn_buffer #(
    parameter int DEPTH  = 8,
    parameter int CODE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      writeValid,
    output logic                      writeReady,
    input  logic [31:0]               writePc,
    input  logic [31:0]               writePcPaddrDebug,
    input  logic [31:0]               writeInsn,
    input  logic                      writeFault,
    input  logic                      writeInterruptValid,
    input  logic [CODE_W-1:0]         writeInterruptCode,
    output logic [CODE_W+81:0]        readEntryLow,
    output logic [CODE_W+81:0]        readEntryHigh,
    output logic [$clog2(DEPTH):0]    readableEntryCount,
    input  logic                      readLow,
    input  logic                      readHigh
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Field order is the bit layout of readEntryLow/readEntryHigh, MSB first.
    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       pc_paddr_debug;
        logic [15:0]       insn;
        logic              fault;
        logic              interrupt_valid;
        logic [CODE_W-1:0] interrupt_code;
    } entry_t;

    entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              ready_r;
    entry_t            low_r;
    entry_t            high_r;

    logic              accept_s;
    logic              wr_en0_s;
    logic              wr_en1_s;
    logic [PTR_W-1:0]  tail_inc_s;
    logic [PTR_W-1:0]  head_next_s;
    logic [PTR_W-1:0]  tail_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [CNT_W-1:0]  push_cnt_s;
    logic [CNT_W-1:0]  pop_req_s;
    logic [CNT_W-1:0]  pop_cnt_s;
    logic              ready_next_s;
    entry_t            entry0_s;
    entry_t            entry1_s;
    entry_t            low_next_s;
    entry_t            high_next_s;

    // Value a slot will hold after the coming edge, including this cycle's writes.
    function automatic entry_t peek_next(input logic [PTR_W-1:0] idx);
        entry_t e;
        if (wr_en1_s && (idx == tail_inc_s)) begin
            e = entry1_s;
        end else if (wr_en0_s && (idx == tail_r)) begin
            e = entry0_s;
        end else begin
            e = mem_r[idx];
        end
        return e;
    endfunction

    // Build the entries carried by an accepted fetch word.
    always_comb begin
        entry0_s                 = '0;
        entry1_s                 = '0;
        entry0_s.pc              = writePc;
        entry0_s.pc_paddr_debug  = writePcPaddrDebug;
        entry0_s.fault           = writeFault;
        entry0_s.interrupt_valid = writeInterruptValid;
        entry0_s.interrupt_code  = writeInterruptCode;
        if (writePc[1]) begin
            entry0_s.insn = writeInsn[31:16];
        end else begin
            entry0_s.insn = writeInsn[15:0];
        end
        entry1_s                 = entry0_s;
        entry1_s.pc              = writePc + 32'd2;
        entry1_s.pc_paddr_debug  = writePcPaddrDebug + 32'd2;
        entry1_s.insn            = writeInsn[31:16];
    end

    // Push/pop accounting and next pointer/count state.
    always_comb begin
        accept_s   = writeValid && ready_r && !flush;
        wr_en0_s   = accept_s;
        wr_en1_s   = accept_s && !writePc[1];
        tail_inc_s = tail_r + PTR_W'(1);
        push_cnt_s = CNT_W'(0);
        if (wr_en1_s) begin
            push_cnt_s = CNT_W'(2);
        end else if (wr_en0_s) begin
            push_cnt_s = CNT_W'(1);
        end else begin
            push_cnt_s = CNT_W'(0);
        end
        pop_req_s = CNT_W'(readLow) + CNT_W'(readLow & readHigh);
        // An over-pop is illegal upstream; clamping keeps the count from underflowing.
        if (pop_req_s > count_r) begin
            pop_cnt_s = count_r;
        end else begin
            pop_cnt_s = pop_req_s;
        end
        if (flush) begin
            head_next_s  = PTR_W'(0);
            tail_next_s  = PTR_W'(0);
            count_next_s = CNT_W'(0);
        end else begin
            head_next_s  = head_r + pop_cnt_s[PTR_W-1:0];
            tail_next_s  = tail_r + push_cnt_s[PTR_W-1:0];
            count_next_s = count_r + push_cnt_s - pop_cnt_s;
        end
        ready_next_s = (CNT_W'(DEPTH) - count_next_s) >= CNT_W'(2);
    end

    // Next values of the registered read ports.
    always_comb begin
        low_next_s  = '0;
        high_next_s = '0;
        if (count_next_s >= CNT_W'(1)) begin
            low_next_s = peek_next(head_next_s);
        end else begin
            low_next_s = '0;
        end
        if (count_next_s >= CNT_W'(2)) begin
            high_next_s = peek_next(head_next_s + PTR_W'(1));
        end else begin
            high_next_s = '0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
            ready_r <= 1'b1;
            low_r   <= '0;
            high_r  <= '0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            ready_r <= ready_next_s;
            low_r   <= low_next_s;
            high_r  <= high_next_s;
        end
    end

    // Entry storage; cleared only by reset, a flush just drops the pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en0_s) begin
                mem_r[tail_r] <= entry0_s;
            end
            if (wr_en1_s) begin
                mem_r[tail_inc_s] <= entry1_s;
            end
        end
    end

    assign writeReady         = ready_r;
    assign readableEntryCount = count_r;
    assign readEntryLow       = low_r;
    assign readEntryHigh      = high_r;

endmodule

// File: tb/tb_insn_buffer.sv
// Directed self-checking bench for insn_buffer plus a protocol checker for the read side.
module insn_buffer_chk #(
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   flush,
    input logic                   readLow,
    input logic                   readHigh,
    input logic [$clog2(DEPTH):0] count
);
    a_high_needs_low: assert property (@(posedge clk) disable iff (!rst) readHigh |-> readLow);
    a_no_over_pop: assert property (@(posedge clk) disable iff (!rst || flush)
        (32'(readLow) + 32'(readLow && readHigh)) <= 32'(count));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst) 32'(count) <= DEPTH);
endmodule

module tb_insn_buffer;
    localparam int DEPTH  = 8;
    localparam int CODE_W = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       pc_paddr_debug;
        logic [15:0]       insn;
        logic              fault;
        logic              interrupt_valid;
        logic [CODE_W-1:0] interrupt_code;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   writeValid;
    logic                   writeReady;
    logic [31:0]            writePc;
    logic [31:0]            writePcPaddrDebug;
    logic [31:0]            writeInsn;
    logic                   writeFault;
    logic                   writeInterruptValid;
    logic [CODE_W-1:0]      writeInterruptCode;
    entry_t                 rd_low;
    entry_t                 rd_high;
    logic [$clog2(DEPTH):0] count;
    logic                   readLow;
    logic                   readHigh;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] wr_pc;
    logic [31:0] exp_pop;

    always #5 clk = ~clk;

    insn_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .writeValid(writeValid), .writeReady(writeReady),
        .writePc(writePc), .writePcPaddrDebug(writePcPaddrDebug), .writeInsn(writeInsn),
        .writeFault(writeFault), .writeInterruptValid(writeInterruptValid),
        .writeInterruptCode(writeInterruptCode),
        .readEntryLow(rd_low), .readEntryHigh(rd_high),
        .readableEntryCount(count), .readLow(readLow), .readHigh(readHigh)
    );

    insn_buffer_chk #(.DEPTH(DEPTH)) chk (
        .clk(clk), .rst(rst), .flush(flush),
        .readLow(readLow), .readHigh(readHigh), .count(count)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush               = 1'b0;
        writeValid          = 1'b0;
        readLow             = 1'b0;
        readHigh            = 1'b0;
        writeFault          = 1'b0;
        writeInterruptValid = 1'b0;
        writeInterruptCode  = 4'd0;
    endtask

    task automatic drive_write(input logic [31:0] pc, input logic [31:0] insn);
        writeValid        = 1'b1;
        writePc           = pc;
        writePcPaddrDebug = pc | 32'h8000_0000;
        writeInsn         = insn;
    endtask

    // Each halfword carries the low 16 bits of its own PC, so order and duplication show up.
    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return {pc[15:0] + 16'd2, pc[15:0]};
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        drive_write(32'h0000_0100, 32'hDEAD_BEEF);
        step();
        step();
        check_eq("rst_count", 128'(count), 128'(0));
        check_eq("rst_ready", 128'(writeReady), 128'(1));
        rst = 1'b1;
        idle();
        check_eq("rst_low", 128'(rd_low), 128'(0));
        check_eq("rst_high", 128'(rd_high), 128'(0));

        // Aligned write splits into two entries
        drive_write(32'h0000_1000, 32'h1234_5678);
        step();
        idle();
        check_eq("al_count", 128'(count), 128'(2));
        check_eq("al_low_pc", 128'(rd_low.pc), 128'(32'h1000));
        check_eq("al_low_insn", 128'(rd_low.insn), 128'(16'h5678));
        check_eq("al_high_pc", 128'(rd_high.pc), 128'(32'h1002));
        check_eq("al_high_insn", 128'(rd_high.insn), 128'(16'h1234));
        check_eq("al_high_paddr", 128'(rd_high.pc_paddr_debug), 128'(32'h8000_1002));
        readLow  = 1'b1;
        readHigh = 1'b1;
        step();
        idle();
        check_eq("al_pop_count", 128'(count), 128'(0));
        check_eq("al_pop_low", 128'(rd_low), 128'(0));

        // Misaligned write pushes only the upper halfword
        drive_write(32'h0000_1002, 32'hABCD_0001);
        step();
        idle();
        check_eq("mis_count", 128'(count), 128'(1));
        check_eq("mis_low_pc", 128'(rd_low.pc), 128'(32'h1002));
        check_eq("mis_low_insn", 128'(rd_low.insn), 128'(16'hABCD));
        check_eq("mis_low_paddr", 128'(rd_low.pc_paddr_debug), 128'(32'h8000_1002));
        check_eq("mis_high_zero", 128'(rd_high), 128'(0));
        drive_write(32'h0000_1004, 32'h1111_2222);
        step();
        idle();
        check_eq("mis2_count", 128'(count), 128'(3));
        check_eq("mis2_low_pc", 128'(rd_low.pc), 128'(32'h1002));
        check_eq("mis2_high_pc", 128'(rd_high.pc), 128'(32'h1004));
        check_eq("mis2_high_insn", 128'(rd_high.insn), 128'(16'h2222));
        readLow  = 1'b1;
        readHigh = 1'b1;
        step();
        idle();
        check_eq("mis3_count", 128'(count), 128'(1));
        check_eq("mis3_low_pc", 128'(rd_low.pc), 128'(32'h1006));
        check_eq("mis3_low_insn", 128'(rd_low.insn), 128'(16'h1111));
        readLow = 1'b1;
        step();
        idle();
        check_eq("mis4_count", 128'(count), 128'(0));

        // Fill to DEPTH, confirm writes are refused and readiness needs two free slots
        for (int i = 0; i < 4; i++) begin
            drive_write(32'h0000_3000 + 32'(4 * i), insn_of(32'h0000_3000 + 32'(4 * i)));
            step();
        end
        idle();
        check_eq("full_count", 128'(count), 128'(8));
        check_eq("full_ready", 128'(writeReady), 128'(0));
        drive_write(32'h0000_4000, 32'h7777_8888);
        step();
        idle();
        check_eq("full_ign_count", 128'(count), 128'(8));
        check_eq("full_ign_low", 128'(rd_low.pc), 128'(32'h3000));
        readLow = 1'b1;
        step();
        idle();
        check_eq("full7_count", 128'(count), 128'(7));
        check_eq("full7_ready", 128'(writeReady), 128'(0));
        check_eq("full7_low", 128'(rd_low.pc), 128'(32'h3002));
        readLow = 1'b1;
        step();
        idle();
        check_eq("full6_count", 128'(count), 128'(6));
        check_eq("full6_ready", 128'(writeReady), 128'(1));
        check_eq("full6_high", 128'(rd_high.pc), 128'(32'h3006));
        for (int i = 0; i < 3; i++) begin
            readLow  = 1'b1;
            readHigh = 1'b1;
            step();
        end
        idle();
        check_eq("drain_count", 128'(count), 128'(0));

        // Streaming across pointer wrap
        wr_pc   = 32'h0000_5000;
        exp_pop = 32'h0000_5000;
        drive_write(wr_pc, insn_of(wr_pc));
        step();
        idle();
        wr_pc = wr_pc + 32'd4;
        for (int i = 0; i < 20; i++) begin
            check_eq("str_low_pc", 128'(rd_low.pc), 128'(exp_pop));
            check_eq("str_high_pc", 128'(rd_high.pc), 128'(exp_pop + 32'd2));
            check_eq("str_low_insn", 128'(rd_low.insn), 128'(exp_pop[15:0]));
            drive_write(wr_pc, insn_of(wr_pc));
            readLow  = 1'b1;
            readHigh = 1'b1;
            step();
            idle();
            wr_pc   = wr_pc + 32'd4;
            exp_pop = exp_pop + 32'd4;
        end
        check_eq("str_count", 128'(count), 128'(2));
        for (int i = 0; i < 4; i++) begin
            check_eq("mix_low_pc", 128'(rd_low.pc), 128'(exp_pop));
            drive_write(wr_pc, insn_of(wr_pc));
            readLow = 1'b1;
            step();
            idle();
            wr_pc   = wr_pc + 32'd4;
            exp_pop = exp_pop + 32'd2;
        end
        check_eq("mix_count", 128'(count), 128'(6));
        for (int i = 0; i < 6; i++) begin
            check_eq("mixd_low_pc", 128'(rd_low.pc), 128'(exp_pop));
            check_eq("mixd_low_insn", 128'(rd_low.insn), 128'(exp_pop[15:0]));
            readLow = 1'b1;
            step();
            idle();
            exp_pop = exp_pop + 32'd2;
        end
        check_eq("mixd_count", 128'(count), 128'(0));
        check_eq("mixd_low", 128'(rd_low), 128'(0));

        // Flush beats a same-cycle write and pop
        drive_write(32'h0000_6000, 32'h9999_AAAA);
        step();
        idle();
        check_eq("pre_fl_count", 128'(count), 128'(2));
        flush = 1'b1;
        drive_write(32'h0000_2000, 32'h5555_6666);
        readLow = 1'b1;
        step();
        idle();
        check_eq("fl_count", 128'(count), 128'(0));
        check_eq("fl_low", 128'(rd_low), 128'(0));
        check_eq("fl_ready", 128'(writeReady), 128'(1));
        drive_write(32'h0000_7000, 32'hCAFE_BABE);
        writeFault          = 1'b1;
        writeInterruptValid = 1'b1;
        writeInterruptCode  = 4'd7;
        step();
        idle();
        check_eq("flt_count", 128'(count), 128'(2));
        check_eq("flt_low_pc", 128'(rd_low.pc), 128'(32'h7000));
        check_eq("flt_low_insn", 128'(rd_low.insn), 128'(16'hBABE));
        check_eq("flt_high_insn", 128'(rd_high.insn), 128'(16'hCAFE));
        check_eq("flt_low_tags", 128'({rd_low.fault, rd_low.interrupt_valid, rd_low.interrupt_code}),
                 128'(6'b11_0111));
        check_eq("flt_high_tags", 128'({rd_high.fault, rd_high.interrupt_valid, rd_high.interrupt_code}),
                 128'(6'b11_0111));

        // Reset in the middle of operation
        rst = 1'b0;
        step();
        check_eq("mrst_count", 128'(count), 128'(0));
        check_eq("mrst_low", 128'(rd_low), 128'(0));
        check_eq("mrst_high", 128'(rd_high), 128'(0));
        check_eq("mrst_ready", 128'(writeReady), 128'(1));
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
